regfile_mp: RTL and testbench

- Parametrised successor to the team's dual-read/single-write register file, built for the next pipeline generation.
- Provides NUM_RD read ports and two write ports, all on one clock, with registered reads and optional same-cycle write-to-read bypass.
- Register 0 is hardwired to zero.
- A built-in clear sequencer zeroes every entry after reset, so the array never comes up uninitialised.
- Sits between decode (read addresses) and writeback (write ports) of the CPU core.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_rd_port.sv | 60 ++++++
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Imported by the top and by the per-port read module.
package regfile_pkg;

    localparam int MAX_RD = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Bit offset of port k inside a bus packing several fields of width w.
    function automatic int port_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: zero-reg / bypass / array priority mux feeding the
// registered data output and its one-cycle valid strobe.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iEn,
    input  logic [ADDR_WIDTH-1:0] iAddr,
    input  logic [DATA_WIDTH-1:0] iMemData,
    input  logic                  iEnWrite0,
    input  logic [ADDR_WIDTH-1:0] iAddrWrite0,
    input  logic [DATA_WIDTH-1:0] iDataWrite0,
    input  logic                  iEnWrite1,
    input  logic [ADDR_WIDTH-1:0] iAddrWrite1,
    input  logic [DATA_WIDTH-1:0] iDataWrite1,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oValid
);

    logic [DATA_WIDTH-1:0] src_data;
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  valid_d, valid_q;

    // Port 1 is checked before port 0 so bypass agrees with the array's
    // "port 1 wins" collision rule.
    always_comb begin
        src_data = iMemData;
        if (ZERO_REG != 0 && iAddr == '0)
            src_data = '0;
        else if (BYPASS != 0 && iEnWrite1 && iAddrWrite1 == iAddr)
            src_data = iDataWrite1;
        else if (BYPASS != 0 && iEnWrite0 && iAddrWrite0 == iAddr)
            src_data = iDataWrite0;
    end

    always_comb begin
        data_d  = iEn ? src_data : data_q;
        valid_d = iEn;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign oData  = data_q;
    assign oValid = valid_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with a post-reset clear sequencer
// that zeroes every entry before oReady is raised.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         iClk,
    input  logic                         iRst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] iAddrRead,
    input  logic [NUM_RD-1:0]            iEnRead,
    output logic [NUM_RD*DATA_WIDTH-1:0] oDataRead,
    output logic [NUM_RD-1:0]            oValidRead,
    input  logic [ADDR_WIDTH-1:0]        iAddrWrite0,
    input  logic [DATA_WIDTH-1:0]        iDataWrite0,
    input  logic                         iEnWrite0,
    input  logic [ADDR_WIDTH-1:0]        iAddrWrite1,
    input  logic [DATA_WIDTH-1:0]        iDataWrite1,
    input  logic                         iEnWrite1,
    output logic                         oReady
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (NUM_RD < 1 || NUM_RD > MAX_RD) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD must be in 1..4");
    end

    state_e                  state_d, state_q;
    logic [ADDR_WIDTH-1:0]   cnt_d, cnt_q;
    logic                    run;
    logic                    clr_we;
    logic                    we0, we1;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter parks at the last address instead of wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == LAST_ADDR) state_d = RUN;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        run    = (state_q == RUN);
        clr_we = (state_q == CLEAR);
        oReady = run;
    end

    assign we0 = run && !iRst && iEnWrite0 && !(ZERO_REG != 0 && iAddrWrite0 == '0);
    assign we1 = run && !iRst && iEnWrite1 && !(ZERO_REG != 0 && iAddrWrite1 == '0);

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge iClk) begin
        if (clr_we) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (we0) mem_q[iAddrWrite0] <= iDataWrite0;
            if (we1) mem_q[iAddrWrite1] <= iDataWrite1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic                  rd_en;

        assign rd_addr = iAddrRead[port_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
        assign rd_en   = run && iEnRead[k];

        regfile_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .BYPASS     (BYPASS),
            .ZERO_REG   (ZERO_REG)
        ) u_rd (
            .iClk        (iClk),
            .iRst        (iRst),
            .iEn         (rd_en),
            .iAddr       (rd_addr),
            .iMemData    (mem_q[rd_addr]),
            .iEnWrite0   (iEnWrite0),
            .iAddrWrite0 (iAddrWrite0),
            .iDataWrite0 (iDataWrite0),
            .iEnWrite1   (iEnWrite1),
            .iAddrWrite1 (iAddrWrite1),
            .iDataWrite1 (iDataWrite1),
            .oData       (oDataRead[port_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
            .oValid      (oValidRead[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one non-bypassing
// instance driven by identical stimulus.
module tb_regfile_mp;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [9:0]  iAddrRead;
    logic [1:0]  iEnRead;
    logic [4:0]  iAddrWrite0, iAddrWrite1;
    logic [31:0] iDataWrite0, iDataWrite1;
    logic        iEnWrite0, iEnWrite1;

    logic [63:0] rd_b, rd_n;
    logic [1:0]  vld_b, vld_n;
    logic        rdy_b, rdy_n;

    int total = 0;
    int bad   = 0;

    always #5 iClk = ~iClk;

    regfile_mp #(.BYPASS(1)) dut (
        .iClk(iClk), .iRst(iRst),
        .iAddrRead(iAddrRead), .iEnRead(iEnRead),
        .oDataRead(rd_b), .oValidRead(vld_b),
        .iAddrWrite0(iAddrWrite0), .iDataWrite0(iDataWrite0), .iEnWrite0(iEnWrite0),
        .iAddrWrite1(iAddrWrite1), .iDataWrite1(iDataWrite1), .iEnWrite1(iEnWrite1),
        .oReady(rdy_b)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .iClk(iClk), .iRst(iRst),
        .iAddrRead(iAddrRead), .iEnRead(iEnRead),
        .oDataRead(rd_n), .oValidRead(vld_n),
        .iAddrWrite0(iAddrWrite0), .iDataWrite0(iDataWrite0), .iEnWrite0(iEnWrite0),
        .iAddrWrite1(iAddrWrite1), .iDataWrite1(iDataWrite1), .iEnWrite1(iEnWrite1),
        .oReady(rdy_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle();
        iEnRead   = 2'b00;
        iEnWrite0 = 1'b0;
        iEnWrite1 = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input bit chk_no_valid);
        int n = 0;
        while (!rdy_b && n < 40) begin
            tick();
            n++;
            if (chk_no_valid) chk({tag, "_novalid"}, {62'd0, vld_b}, 64'd0);
        end
        chk({tag, "_cycles"}, 64'(n), 64'd32);
        chk({tag, "_rdy_nb"}, {63'd0, rdy_n}, 64'd1);
    endtask

    initial begin
        iRst = 1'b1;
        iAddrRead = '0; iAddrWrite0 = '0; iAddrWrite1 = '0;
        iDataWrite0 = '0; iDataWrite1 = '0;
        idle();

        // reset held two cycles
        tick(); tick();
        chk("rst_ready", {63'd0, rdy_b}, 64'd0);
        chk("rst_valid", {62'd0, vld_b}, 64'd0);
        chk("rst_data",  rd_b, 64'd0);
        iRst = 1'b0;
        wait_ready("clear", 1'b0);

        // every entry zero after clear
        for (int a = 0; a < 32; a += 2) begin
            iAddrRead = {5'(a + 1), 5'(a)};
            iEnRead   = 2'b11;
            tick();
            chk($sformatf("clr_rd%0d", a), rd_b, 64'd0);
            chk($sformatf("clr_vld%0d", a), {62'd0, vld_b}, 64'd3);
        end
        idle();

        // write r5 then read on both ports
        iAddrWrite0 = 5'd5; iDataWrite0 = 32'hDEADBEEF; iEnWrite0 = 1'b1;
        tick(); idle();
        iAddrRead = {5'd5, 5'd5}; iEnRead = 2'b11;
        tick(); idle();
        chk("wr_rd_data",  rd_b, {32'hDEADBEEF, 32'hDEADBEEF});
        chk("wr_rd_valid", {62'd0, vld_b}, 64'd3);
        tick();
        chk("valid_drop", {62'd0, vld_b}, 64'd0);

        // same-address write collision: port 1 wins
        iAddrWrite0 = 5'd7; iDataWrite0 = 32'h11111111; iEnWrite0 = 1'b1;
        iAddrWrite1 = 5'd7; iDataWrite1 = 32'h22222222; iEnWrite1 = 1'b1;
        tick(); idle();
        iAddrRead = {5'd0, 5'd7}; iEnRead = 2'b01;
        tick(); idle();
        chk("collide_r7", {32'd0, rd_b[31:0]}, {32'd0, 32'h22222222});

        // r0 ignores writes, and bypass never exposes a write to r0
        iAddrWrite0 = 5'd0; iDataWrite0 = 32'hFFFFFFFF; iEnWrite0 = 1'b1;
        iAddrRead = {5'd0, 5'd7}; iEnRead = 2'b10;
        tick(); idle();
        chk("r0_bypass", {32'd0, rd_b[63:32]}, 64'd0);
        iAddrRead = {5'd0, 5'd0}; iEnRead = 2'b10;
        tick(); idle();
        chk("r0_read", {32'd0, rd_b[63:32]}, 64'd0);

        // bypass on r9
        iAddrWrite0 = 5'd9; iDataWrite0 = 32'hAAAA0000; iEnWrite0 = 1'b1;
        tick(); idle();
        iAddrWrite0 = 5'd9; iDataWrite0 = 32'h12345678; iEnWrite0 = 1'b1;
        iAddrRead = {5'd9, 5'd0}; iEnRead = 2'b10;
        tick(); idle();
        chk("byp_w0",    {32'd0, rd_b[63:32]}, {32'd0, 32'h12345678});
        chk("nobyp_w0",  {32'd0, rd_n[63:32]}, {32'd0, 32'hAAAA0000});
        iAddrWrite0 = 5'd9; iDataWrite0 = 32'h00000001; iEnWrite0 = 1'b1;
        iAddrWrite1 = 5'd9; iDataWrite1 = 32'h00000002; iEnWrite1 = 1'b1;
        iAddrRead = {5'd0, 5'd9}; iEnRead = 2'b01;
        tick(); idle();
        chk("byp_both",   {32'd0, rd_b[31:0]}, 64'd2);
        chk("nobyp_both", {32'd0, rd_n[31:0]}, {32'd0, 32'h12345678});
        iAddrRead = {5'd9, 5'd9}; iEnRead = 2'b11;
        tick(); idle();
        chk("r9_after_b", rd_b, {32'd2, 32'd2});
        chk("r9_after_n", rd_n, {32'd2, 32'd2});

        // read hold with enables low
        iAddrWrite1 = 5'd4; iDataWrite1 = 32'hCAFE0001; iEnWrite1 = 1'b1;
        tick(); idle();
        iAddrRead = {5'd0, 5'd4}; iEnRead = 2'b01;
        tick(); idle();
        chk("hold_load", {32'd0, rd_b[31:0]}, {32'd0, 32'hCAFE0001});
        for (int i = 0; i < 3; i++) begin
            iAddrRead = {5'd9, 5'd9};
            tick();
            chk($sformatf("hold_data%0d", i), {32'd0, rd_b[31:0]}, {32'd0, 32'hCAFE0001});
            chk($sformatf("hold_vld%0d", i), {62'd0, vld_b}, 64'd0);
        end

        // reset in RUN restarts the clear
        iAddrWrite0 = 5'd3; iDataWrite0 = 32'h5; iEnWrite0 = 1'b1;
        tick(); idle();
        iAddrRead = {5'd3, 5'd3}; iEnRead = 2'b11;
        tick();
        chk("r3_before", rd_b, {32'd5, 32'd5});
        iRst = 1'b1;
        tick();
        chk("midrst_ready", {63'd0, rdy_b}, 64'd0);
        chk("midrst_data",  rd_b, 64'd0);
        chk("midrst_valid", {62'd0, vld_b}, 64'd0);
        iRst = 1'b0;
        wait_ready("reclear", 1'b1);
        tick(); idle();
        chk("r3_cleared", rd_b, 64'd0);
        chk("r3_valid",   {62'd0, vld_b}, 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
